// File: rtl/io_input_capture.sv
// Debounced 32-pin input capture with edge-event pending latches and a level interrupt.
// Latency: 2 sync flops + DEB_CNT ticks of DEB_DIV cycles to accept a pin change; reads are zero-latency.
// Backpressure: none; register writes take effect on the strobe edge, events are never dropped.
//
// Ports:
//   clk        rising-edge system clock
//   rst        asynchronous active-low reset
//   pins_In    raw external pins, asynchronous to clk
//   addr_In    register byte address (0x00 STATE, 0x04 RISE_EN, 0x08 FALL_EN, 0x0C PENDING, 0x10 IRQ_EN)
//   we_In      single-cycle write strobe
//   wdata_In   write data
//   rdata_Out  combinational read data for addr_In
//   irq_Out    level interrupt, OR of PENDING & IRQ_EN
module io_input_capture #(
  parameter int DEB_DIV = 16,
  parameter int DEB_CNT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pins_In,
  input  logic [4:0]  addr_In,
  input  logic        we_In,
  input  logic [31:0] wdata_In,
  output logic [31:0] rdata_Out,
  output logic        irq_Out
);

  localparam int PW = $clog2(DEB_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(DEB_DIV - 1);
  localparam logic [2:0]    CNT_HIT  = 3'(DEB_CNT);

  localparam logic [4:0] A_STATE   = 5'h00;
  localparam logic [4:0] A_RISE_EN = 5'h04;
  localparam logic [4:0] A_FALL_EN = 5'h08;
  localparam logic [4:0] A_PENDING = 5'h0C;
  localparam logic [4:0] A_IRQ_EN  = 5'h10;

  logic [31:0]   sync1, sync2;
  logic [PW-1:0] presc;
  logic          tick;
  logic [31:0]   deb_q, deb_d;
  logic [2:0]    cnt_q [32];
  logic [2:0]    cnt_d [32];
  logic [2:0]    cnt_inc [32];
  logic [31:0]   rise_en, fall_en, irq_en, pend_q, pend_d;
  logic [31:0]   rise_evt, fall_evt, w1c_mask;

  assign tick = (presc == PRE_LAST);

  // Per-pin debounce: a pin must disagree with its debounced value on DEB_CNT
  // consecutive ticks; any agreeing tick restarts the count.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 32; i++) begin
      cnt_inc[i] = cnt_q[i] + 3'd1;
      cnt_d[i]   = cnt_q[i];
      if (tick) begin
        if (sync2[i] == deb_q[i]) begin
          cnt_d[i] = 3'd0;
        end else if (cnt_inc[i] == CNT_HIT) begin
          deb_d[i] = sync2[i];
          cnt_d[i] = 3'd0;
        end else begin
          cnt_d[i] = cnt_inc[i];
        end
      end
    end
  end

  assign rise_evt = deb_d & ~deb_q;
  assign fall_evt = ~deb_d & deb_q;
  assign w1c_mask = (we_In && addr_In == A_PENDING) ? wdata_In : 32'h0;

  // Clear is applied before set so a new event on the W1C edge survives.
  assign pend_d = (pend_q & ~w1c_mask) | (rise_evt & rise_en) | (fall_evt & fall_en);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1   <= 32'h0;
      sync2   <= 32'h0;
      presc   <= '0;
      deb_q   <= 32'h0;
      pend_q  <= 32'h0;
      rise_en <= 32'h0;
      fall_en <= 32'h0;
      irq_en  <= 32'h0;
      for (int i = 0; i < 32; i++) cnt_q[i] <= 3'd0;
    end else begin
      sync1  <= pins_In;
      sync2  <= sync1;
      presc  <= tick ? '0 : presc + 1'b1;
      deb_q  <= deb_d;
      pend_q <= pend_d;
      for (int i = 0; i < 32; i++) cnt_q[i] <= cnt_d[i];
      if (we_In && addr_In == A_RISE_EN) rise_en <= wdata_In;
      if (we_In && addr_In == A_FALL_EN) fall_en <= wdata_In;
      if (we_In && addr_In == A_IRQ_EN)  irq_en  <= wdata_In;
    end
  end

  always_comb begin
    case (addr_In)
      A_STATE:   rdata_Out = deb_q;
      A_RISE_EN: rdata_Out = rise_en;
      A_FALL_EN: rdata_Out = fall_en;
      A_PENDING: rdata_Out = pend_q;
      A_IRQ_EN:  rdata_Out = irq_en;
      default:   rdata_Out = 32'h0;
    endcase
  end

  assign irq_Out = |(pend_q & irq_en);

endmodule

// File: tb/tb_io_input_capture.sv
module tb_io_input_capture;

  logic        clk;
  logic        rst;
  logic [31:0] pins;
  logic [4:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int vectors;
  int miscompares;
  int cyc;

  io_input_capture #(.DEB_DIV(4), .DEB_CNT(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .pins_In   (pins),
    .addr_In   (addr),
    .we_In     (we),
    .wdata_In  (wdata),
    .rdata_Out (rdata),
    .irq_Out   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since reset release; the prescaler ticks on every edge that makes this a multiple of 4.
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  // Waits up to max edges for STATE[idx]==val; used = edges waited, or max+1 on timeout.
  task automatic wait_state(input int idx, input logic val, input int max, output int used);
    logic [31:0] v;
    used = max + 1;
    for (int i = 0; i <= max; i++) begin
      rd(5'h00, v);
      if (v[idx] === val) begin
        used = i;
        break;
      end
      step(1);
    end
  endtask

  task automatic test_reset;
    logic [31:0] v;
    rst = 1'b0; pins = 32'h0; addr = 5'h0; we = 1'b0; wdata = 32'h0;
    step(3);
    for (int i = 0; i < 5; i++) begin
      rd(5'(i * 4), v);
      vectors++;
      if (v !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_reg%0d: got %h expected %h", i, v, 32'h0);
      end
    end
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_irq: got %b expected 0", irq);
    end
    #1 rst = 1'b1;
    step(1);
  endtask

  task automatic test_rise;
    logic [31:0] v;
    int used;
    wr(5'h04, 32'h1);
    wr(5'h10, 32'h1);
    pins[0] = 1'b1;
    step(10);
    rd(5'h00, v);
    vectors++;
    if (v !== 32'h0) begin
      miscompares++;
      $display("FAIL rise_early: got %h expected %h", v, 32'h0);
    end
    wait_state(0, 1'b1, 8, used);
    vectors++;
    if (used > 8) begin
      miscompares++;
      $display("FAIL rise_window: got timeout expected STATE[0]=1 within 18 cycles");
    end
    rd(5'h0C, v);
    vectors++;
    if (v !== 32'h1) begin
      miscompares++;
      $display("FAIL rise_pending: got %h expected %h", v, 32'h1);
    end
    vectors++;
    if (irq !== 1'b1) begin
      miscompares++;
      $display("FAIL rise_irq: got %b expected 1", irq);
    end
  endtask

  task automatic test_w1c;
    logic [31:0] v;
    wr(5'h0C, 32'h0);
    rd(5'h0C, v);
    vectors++;
    if (v !== 32'h1) begin
      miscompares++;
      $display("FAIL w1c_zero: got %h expected %h", v, 32'h1);
    end
    wr(5'h0C, 32'h1);
    rd(5'h0C, v);
    vectors++;
    if (v !== 32'h0) begin
      miscompares++;
      $display("FAIL w1c_one: got %h expected %h", v, 32'h0);
    end
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL w1c_irq: got %b expected 0", irq);
    end
  endtask

  task automatic test_glitch;
    logic [31:0] v;
    logic [31:0] p;
    wr(5'h04, 32'h21);
    pins[5] = 1'b1;
    step(6);
    pins[5] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      rd(5'h00, v);
      rd(5'h0C, p);
      vectors++;
      if (v !== 32'h1 || p !== 32'h0 || irq !== 1'b0) begin
        miscompares++;
        $display("FAIL glitch_c%0d: got state %h pend %h irq %b expected 00000001 00000000 0", i, v, p, irq);
      end
      step(1);
    end
  endtask

  task automatic test_collision;
    logic [31:0] v;
    int used;
    pins[0] = 1'b0;
    wait_state(0, 1'b0, 20, used);
    vectors++;
    if (used > 20) begin
      miscompares++;
      $display("FAIL coll_fall: got timeout expected STATE[0]=0");
    end
    for (int i = 0; i < 8 && (cyc % 4) != 0; i++) step(1);
    vectors++;
    if ((cyc % 4) != 0) begin
      miscompares++;
      $display("FAIL coll_align: got cyc %0d expected multiple of 4", cyc);
    end
    pins[0] = 1'b1;
    step(11);
    rd(5'h00, v);
    vectors++;
    if (v[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL coll_pre: got STATE[0]=%b expected 0", v[0]);
    end
    wr(5'h0C, 32'h1);
    rd(5'h00, v);
    vectors++;
    if (v[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL coll_state: got STATE[0]=%b expected 1", v[0]);
    end
    rd(5'h0C, v);
    vectors++;
    if (v !== 32'h1 || irq !== 1'b1) begin
      miscompares++;
      $display("FAIL coll_pending: got %h irq %b expected 00000001 1", v, irq);
    end
  endtask

  task automatic test_fall;
    logic [31:0] v;
    int used;
    wr(5'h0C, 32'hFFFF_FFFF);
    wr(5'h04, 32'h0);
    wr(5'h08, 32'h8000_0000);
    pins[31] = 1'b1;
    wait_state(31, 1'b1, 20, used);
    rd(5'h0C, v);
    vectors++;
    if (used > 20 || v !== 32'h0) begin
      miscompares++;
      $display("FAIL fall_rise_ignored: got wait %0d pend %h expected <=20 00000000", used, v);
    end
    pins[31] = 1'b0;
    wait_state(31, 1'b0, 20, used);
    rd(5'h0C, v);
    vectors++;
    if (used > 20 || v !== 32'h8000_0000) begin
      miscompares++;
      $display("FAIL fall_pending: got wait %0d pend %h expected <=20 80000000", used, v);
    end
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL fall_irq_masked: got %b expected 0", irq);
    end
    wr(5'h10, 32'h8000_0001);
    vectors++;
    if (irq !== 1'b1) begin
      miscompares++;
      $display("FAIL fall_irq: got %b expected 1", irq);
    end
    wr(5'h0C, 32'hFFFF_FFFF);
    wr(5'h08, 32'h0);
    wr(5'h04, 32'h8000_0000);
    pins[31] = 1'b1;
    wait_state(31, 1'b1, 20, used);
    rd(5'h0C, v);
    vectors++;
    if (used > 20 || v !== 32'h8000_0000) begin
      miscompares++;
      $display("FAIL rise31_pending: got wait %0d pend %h expected <=20 80000000", used, v);
    end
    wr(5'h0C, 32'h8000_0000);
    pins[31] = 1'b0;
    wait_state(31, 1'b0, 20, used);
    rd(5'h0C, v);
    vectors++;
    if (used > 20 || v !== 32'h0) begin
      miscompares++;
      $display("FAIL fall31_no_pending: got wait %0d pend %h expected <=20 00000000", used, v);
    end
  endtask

  task automatic test_unmapped;
    logic [31:0] v;
    logic [4:0]  holes [4];
    holes[0] = 5'h14; holes[1] = 5'h18; holes[2] = 5'h1C; holes[3] = 5'h02;
    for (int i = 0; i < 4; i++) begin
      wr(holes[i], 32'hDEAD_BEEF);
      rd(holes[i], v);
      vectors++;
      if (v !== 32'h0) begin
        miscompares++;
        $display("FAIL unmapped_%h: got %h expected %h", holes[i], v, 32'h0);
      end
    end
    rd(5'h04, v);
    vectors++;
    if (v !== 32'h8000_0000) begin
      miscompares++;
      $display("FAIL unmapped_rise_en: got %h expected %h", v, 32'h8000_0000);
    end
    rd(5'h10, v);
    vectors++;
    if (v !== 32'h8000_0001) begin
      miscompares++;
      $display("FAIL unmapped_irq_en: got %h expected %h", v, 32'h8000_0001);
    end
    wr(5'h00, 32'hFFFF_FFFF);
    rd(5'h00, v);
    vectors++;
    if (v !== 32'h1) begin
      miscompares++;
      $display("FAIL state_write: got %h expected %h", v, 32'h1);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] v;
    int used;
    pins[31] = 1'b1;
    wait_state(31, 1'b1, 20, used);
    vectors++;
    if (used > 20 || irq !== 1'b1) begin
      miscompares++;
      $display("FAIL rmid_setup: got wait %0d irq %b expected <=20 1", used, irq);
    end
    pins[31] = 1'b0;
    step(5);
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rd(5'(i * 4), v);
      vectors++;
      if (v !== 32'h0) begin
        miscompares++;
        $display("FAIL rmid_reg%0d: got %h expected %h", i, v, 32'h0);
      end
    end
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL rmid_irq: got %b expected 0", irq);
    end
    step(2);
    #2 rst = 1'b1;
    step(11);
    rd(5'h00, v);
    vectors++;
    if (v !== 32'h0) begin
      miscompares++;
      $display("FAIL rmid_early: got %h expected %h", v, 32'h0);
    end
    step(1);
    rd(5'h00, v);
    vectors++;
    if (v !== 32'h1) begin
      miscompares++;
      $display("FAIL rmid_state: got %h expected %h", v, 32'h1);
    end
    rd(5'h0C, v);
    vectors++;
    if (v !== 32'h0 || irq !== 1'b0) begin
      miscompares++;
      $display("FAIL rmid_pending: got %h irq %b expected 00000000 0", v, irq);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset;
    test_rise;
    test_w1c;
    test_glitch;
    test_collision;
    test_fall;
    test_unmapped;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/io_input_capture.md
IO_INPUT_CAPTURE -- requirements
Module: io_input_capture

Interface
REQ-001 SHALL have parameter DEB_DIV, default 16, meaning clock cycles per debounce sample tick (>=2).
REQ-002 SHALL have parameter DEB_CNT, default 3, meaning consecutive differing samples needed to accept a pin change (1..7).
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk, input, 1, rising-edge system clock.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port pins_In, input, 32, raw external input pins, asynchronous to clk.
REQ-007 SHALL have port addr_In, input, 5, byte address of register: 0x00 STATE, 0x04 RISE_EN, 0x08 FALL_EN, 0x0C PENDING, 0x10 IRQ_EN.
REQ-008 SHALL have port we_In, input, 1, single-cycle write strobe.
REQ-009 SHALL have port wdata_In, input, 32, write data.
REQ-010 SHALL have port rdata_Out, output, 32, combinational read data for addr_In.
REQ-011 SHALL have port irq_Out, output, 1, level interrupt request.

Function
REQ-012 SHALL pass each pin through a two-flop synchronizer; stage-2 output is the sample value.
REQ-013 SHALL run a free-running prescaler 0..DEB_DIV-1, wrapping to 0; tick is a one-cycle pulse while prescaler == DEB_DIV-1.
REQ-014 SHALL keep per pin a debounced bit and a 3-bit counter, updated only on tick.
REQ-015 SHALL, on tick where sample == debounced bit, clear that pin's counter.
REQ-016 SHALL, on tick where sample != debounced bit, increment the counter; when the incremented value equals DEB_CNT, load the debounced bit from sample and clear the counter on the same edge.
REQ-017 SHALL detect a rising event when the debounced bit goes 0->1, falling event when 1->0, on the edge the bit changes.
REQ-018 SHALL set PENDING[i] on the same edge as an event on pin i if the matching RISE_EN[i]/FALL_EN[i] is 1; PENDING is sticky.
REQ-019 SHALL clear PENDING bits written with 1 at 0x0C (write-1-to-clear); bits written 0 unchanged.
REQ-020 SHALL keep PENDING[i] = 1 when a W1C of bit i and a new enabled event on pin i occur on the same edge (set wins).
REQ-021 SHALL load RISE_EN, FALL_EN, IRQ_EN fully from wdata_In on write; STATE writes ignored.
REQ-022 SHALL return 0 on reads of unmapped addresses and ignore writes to them.
REQ-023 SHALL return STATE = debounced bits, other registers = current contents, with zero latency.
REQ-024 SHALL drive irq_Out = OR of (PENDING & IRQ_EN), combinational from registers.
REQ-025 SHALL not alter enable registers on events; enabling after an event does not retroactively set PENDING.

Reset
REQ-026 SHALL, while rst is 0, asynchronously clear synchronizers, prescaler, counters, debounced bits, RISE_EN, FALL_EN, PENDING, IRQ_EN; irq_Out = 0; rdata_Out = 0 for all addresses.
REQ-027 SHALL, after rst release, restart prescaler from 0; a pin held high through reset is reported only after a full debounce window and generates no PENDING unless enabled beforehand.

Verification (DEB_DIV=4, DEB_CNT=3)
REQ-028 SHALL cover: RISE_EN=IRQ_EN=0x1, pins_In[0] 0->1 held -> STATE[0]=1 within 2+12+4 cycles, PENDING=0x1, irq_Out=1.
REQ-029 SHALL cover: pins_In[5] high for 6 cycles (2 ticks) then low -> STATE=0, PENDING=0, irq_Out=0 throughout.
REQ-030 SHALL cover: PENDING=0x1, write 0x0 to 0x0C -> unchanged; write 0x1 -> PENDING=0, irq_Out=0 next cycle.
REQ-031 SHALL cover: W1C of bit 0 on the exact edge a new rising event on pin 0 is accepted -> PENDING[0]=1.
REQ-032 SHALL cover: FALL_EN=0x80000000, pins_In[31] debounced high then low -> PENDING=0x80000000, RISE_EN-only edges produce no pending.
REQ-033 SHALL cover: rst pulled low mid-debounce between clock edges -> all registers/outputs 0 before next edge; after release with pin high, STATE[0]=1 only after full window, PENDING=0.
